bus_timer_port: RTL and testbench



---
 rtl/bus_timer_port.sv | 163 ++++++++++++++++
 tb/tb_bus_timer_port.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/bus_timer_port.sv
// -----------------------------------------------------------------------------
// bus_timer_port
//   Memory-mapped responder on the mc6502 CPU bus: an 8-bit bidirectional I/O
//   port (ORA data + DDRA direction) and an 8-bit interval timer with a
//   selectable 1/8/64/1024 prescaler and an underflow flag.
//
//   Read data is combinational within the addressed cycle; writes commit on
//   the CLK edge that ends the cycle.
//
//   Register map (ADDR[2:0]):
//     0  R/W  ORA     read = (PA_IN & ~DDRA) | (ORA & DDRA)
//     1  R/W  DDRA    1 = output
//     2  R    INTIM   timer count; the read clears the flag at the clock edge
//     3  R    TIMSTAT {flag, 7'b0}
//     4-7 W   load timer, prescale 1/8/64/1024; ADDR[3] = interrupt enable
//
// Ports:
//   CLK     clock
//   RES     asynchronous active-high reset
//   CS      chip select from the external address decoder
//   RW      1 = CPU read, 0 = CPU write
//   ADDR    register select (low address bits)
//   DB_IN   CPU write data
//   DB_OUT  read data, combinational, 8'h00 when not reading
//   PA_IN   port pin input
//   PA_OUT  port output value (ORA)
//   PA_OE   port output enable (DDRA)
//   IRQ_N   active-low interrupt request
//
// Build option:
//   BUS_TIMER_PORT_IRQ_EN  when defined, IE is implemented and
//                          IRQ_N = ~(flag & IE), registered. When undefined,
//                          IRQ_N is tied high and ADDR[3] is ignored.
// -----------------------------------------------------------------------------
module bus_timer_port #(
    parameter logic [7:0] P_ORA_INIT  = 8'h00,
    parameter logic [7:0] P_DDRA_INIT = 8'h00,
    parameter logic [7:0] P_TIM_INIT  = 8'h00
) (
    input  logic       CLK,
    input  logic       RES,
    input  logic       CS,
    input  logic       RW,
    input  logic [3:0] ADDR,
    input  logic [7:0] DB_IN,
    output logic [7:0] DB_OUT,
    input  logic [7:0] PA_IN,
    output logic [7:0] PA_OUT,
    output logic [7:0] PA_OE,
    output logic       IRQ_N
);

    logic [7:0] ora;
    logic [7:0] ddra;
    logic [7:0] count;
    logic [1:0] sel;
    logic [9:0] pre_cnt;
    logic [9:0] pre_limit;
    logic       flag;
    logic       free_run;

    logic rd;
    logic wr;
    logic tim_wr;
    logic intim_rd;
    logic tick;
    logic set_flag;
    logic flag_nxt;

    assign rd       = CS & RW;
    assign wr       = CS & ~RW;
    assign tim_wr   = wr & ADDR[2];
    assign intim_rd = rd & (ADDR[2:0] == 3'd2);

    always_comb begin
        pre_limit = 10'd1023;
        case (sel)
            2'd0:    pre_limit = 10'd0;
            2'd1:    pre_limit = 10'd7;
            2'd2:    pre_limit = 10'd63;
            default: pre_limit = 10'd1023;
        endcase
    end

    // After the first underflow the timer free-runs at one decrement per
    // clock; only that first underflow raises the flag.
    assign tick     = free_run | (pre_cnt == pre_limit);
    assign set_flag = tick & ~free_run & (count == 8'h00);

    // Priority: timer write clears, then a flag set beats an INTIM read clear.
    assign flag_nxt = tim_wr   ? 1'b0 :
                      set_flag ? 1'b1 :
                      intim_rd ? 1'b0 : flag;

    always_ff @(posedge CLK or posedge RES) begin
        if (RES) begin
            ora      <= P_ORA_INIT;
            ddra     <= P_DDRA_INIT;
            count    <= P_TIM_INIT;
            sel      <= 2'd3;
            pre_cnt  <= 10'd0;
            flag     <= 1'b0;
            free_run <= 1'b0;
        end else begin
            if (wr && ADDR[2:0] == 3'd0) ora  <= DB_IN;
            if (wr && ADDR[2:0] == 3'd1) ddra <= DB_IN;

            flag <= flag_nxt;

            if (tim_wr) begin
                count    <= DB_IN;
                sel      <= ADDR[1:0];
                pre_cnt  <= 10'd0;
                free_run <= 1'b0;
            end else begin
                pre_cnt <= tick ? 10'd0 : pre_cnt + 10'd1;
                // 8'h00 - 1 wraps to 8'hFF, covering both underflow and
                // free-run wrap.
                if (tick) count <= count - 8'd1;
                if (set_flag) free_run <= 1'b1;
            end
        end
    end

`ifdef BUS_TIMER_PORT_IRQ_EN
    logic ie;
    logic ie_nxt;

    assign ie_nxt = tim_wr ? ADDR[3] : ie;

    always_ff @(posedge CLK or posedge RES) begin
        if (RES) begin
            ie    <= 1'b0;
            IRQ_N <= 1'b1;
        end else begin
            ie    <= ie_nxt;
            IRQ_N <= ~(flag_nxt & ie_nxt);
        end
    end
`else
    logic unused_addr3;

    assign unused_addr3 = ADDR[3];
    assign IRQ_N        = 1'b1;
`endif

    always_comb begin
        DB_OUT = 8'h00;
        if (rd) begin
            case (ADDR[2:0])
                3'd0:    DB_OUT = (PA_IN & ~ddra) | (ora & ddra);
                3'd1:    DB_OUT = ddra;
                3'd2:    DB_OUT = count;
                3'd3:    DB_OUT = {flag, 7'b0};
                default: DB_OUT = 8'h00;
            endcase
        end
    end

    assign PA_OUT = ora;
    assign PA_OE  = ddra;

endmodule

// File: tb/tb_bus_timer_port.sv
module tb_bus_timer_port;

`ifdef BUS_TIMER_PORT_IRQ_EN
    localparam bit IRQ_EN = 1'b1;
`else
    localparam bit IRQ_EN = 1'b0;
`endif

    logic       CLK;
    logic       RES;
    logic       CS;
    logic       RW;
    logic [3:0] ADDR;
    logic [7:0] DB_IN;
    logic [7:0] DB_OUT;
    logic [7:0] PA_IN;
    logic [7:0] PA_OUT;
    logic [7:0] PA_OE;
    logic       IRQ_N;

    int checks   = 0;
    int failures = 0;

    bus_timer_port dut (
        .CLK   (CLK),
        .RES   (RES),
        .CS    (CS),
        .RW    (RW),
        .ADDR  (ADDR),
        .DB_IN (DB_IN),
        .DB_OUT(DB_OUT),
        .PA_IN (PA_IN),
        .PA_OUT(PA_OUT),
        .PA_OE (PA_OE),
        .IRQ_N (IRQ_N)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Behavioural model: timer described as "clocks elapsed since last
    // decrement" against a period in clocks.
    logic [7:0] m_ora, m_ddra, m_count;
    bit         m_flag, m_ie, m_free;
    int         m_period, m_elapsed;

    task automatic model_reset();
        m_ora = 8'h00; m_ddra = 8'h00; m_count = 8'h00;
        m_flag = 0; m_ie = 0; m_free = 0;
        m_period = 1024; m_elapsed = 0;
    endtask

    function automatic logic [7:0] model_read(input logic cs, input logic rw,
                                              input logic [3:0] a, input logic [7:0] pa);
        if (!(cs && rw)) return 8'h00;
        case (a[2:0])
            3'd0:    return (pa & ~m_ddra) | (m_ora & m_ddra);
            3'd1:    return m_ddra;
            3'd2:    return m_count;
            3'd3:    return m_flag ? 8'h80 : 8'h00;
            default: return 8'h00;
        endcase
    endfunction

    function automatic bit model_irq_n();
        return IRQ_EN ? !(m_flag && m_ie) : 1'b1;
    endfunction

    task automatic model_step(input logic cs, input logic rw,
                              input logic [3:0] a, input logic [7:0] d);
        bit just_set;
        just_set = 0;
        if (cs && !rw && a[2]) begin
            m_count   = d;
            m_period  = (a[1:0] == 2'd0) ? 1 : (a[1:0] == 2'd1) ? 8 :
                        (a[1:0] == 2'd2) ? 64 : 1024;
            m_elapsed = 0;
            m_flag    = 0;
            m_free    = 0;
            m_ie      = IRQ_EN ? a[3] : 1'b0;
        end else begin
            if (cs && !rw && a[2:0] == 3'd0) m_ora  = d;
            if (cs && !rw && a[2:0] == 3'd1) m_ddra = d;
            m_elapsed++;
            if (m_free || m_elapsed == m_period) begin
                m_elapsed = 0;
                if (m_count == 8'h00 && !m_free) begin
                    m_flag = 1; m_free = 1; just_set = 1;
                end
                m_count = m_count - 8'd1;
            end
            if (cs && rw && a[2:0] == 3'd2 && !just_set) m_flag = 0;
        end
    endtask

    task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One bus cycle: drive, compare combinational outputs mid-cycle, clock,
    // advance the model. exp_db / exp_irq < 0 means no extra constant check.
    task automatic do_cycle(input string tag, input logic cs, input logic rw,
                            input logic [3:0] a, input logic [7:0] d,
                            input int exp_db, input int exp_irq);
        CS = cs; RW = rw; ADDR = a; DB_IN = d;
        #1;
        check8({tag, "_db_model"}, DB_OUT, model_read(cs, rw, a, PA_IN));
        check8({tag, "_pa_out"}, PA_OUT, m_ora);
        check8({tag, "_pa_oe"}, PA_OE, m_ddra);
        check8({tag, "_irq_model"}, {7'b0, IRQ_N}, {7'b0, model_irq_n()});
        if (exp_db >= 0) check8({tag, "_db_const"}, DB_OUT, exp_db[7:0]);
        if (exp_irq >= 0) check8({tag, "_irq_const"}, {7'b0, IRQ_N}, {7'b0, exp_irq[0]});
        @(posedge CLK);
        model_step(cs, rw, a, d);
        #1;
    endtask

    initial begin
        RES = 1'b1; CS = 1'b1; RW = 1'b1; ADDR = 4'h0; DB_IN = 8'h00; PA_IN = 8'h00;
        model_reset();

        // Reads during reset.
        for (int i = 0; i < 4; i++) begin
            ADDR = i[3:0];
            #1;
            check8("rst_hold_db", DB_OUT, 8'h00);
            check8("rst_hold_irq", {7'b0, IRQ_N}, 8'h01);
        end
        @(posedge CLK); @(negedge CLK);
        RES = 1'b0;
        for (int i = 0; i < 4; i++)
            do_cycle("rst_read", 1, 1, i[3:0], 8'h00, 0, 1);

        // Port.
        PA_IN = 8'h3C;
        do_cycle("wr_ddra", 1, 0, 4'h1, 8'hF0, 0, -1);
        do_cycle("wr_ora", 1, 0, 4'h0, 8'hA5, 0, -1);
        check8("pa_oe_const", PA_OE, 8'hF0);
        check8("pa_out_const", PA_OUT, 8'hA5);
        do_cycle("rd_ora", 1, 1, 4'h0, 8'h00, 8'hAC, -1);
        do_cycle("rd_ddra", 1, 1, 4'h1, 8'h00, 8'hF0, -1);

        // Prescale 8 countdown from 3.
        do_cycle("ld5", 1, 0, 4'h5, 8'h03, 0, -1);
        for (int c = 0; c < 32; c++)
            do_cycle("pre8", 1, 1, 4'h2, 8'h00, 3 - c / 8, -1);
        do_cycle("pre8_stat", 1, 1, 4'h3, 8'h00, 8'h80, -1);
        do_cycle("pre8_fe", 1, 1, 4'h2, 8'h00, 8'hFE, -1);
        do_cycle("pre8_fd", 1, 1, 4'h2, 8'h00, 8'hFD, -1);

        // Prescale 1 from 0, INTIM read clears flag, free-run continues.
        do_cycle("ld4", 1, 0, 4'h4, 8'h00, 0, -1);
        do_cycle("p1_c0", 1, 1, 4'h2, 8'h00, 8'h00, -1);
        do_cycle("p1_stat", 1, 1, 4'h3, 8'h00, 8'h80, -1);
        do_cycle("p1_rd", 1, 1, 4'h2, 8'h00, 8'hFE, -1);
        do_cycle("p1_clr", 1, 1, 4'h3, 8'h00, 8'h00, -1);
        do_cycle("p1_fc", 1, 1, 4'h2, 8'h00, 8'hFC, -1);
        for (int c = 0; c < 260; c++)
            do_cycle("freerun", (c % 3) != 0, 1, (c % 2) ? 4'h2 : 4'h3, 8'h00, -1, -1);
        do_cycle("freerun_stat", 1, 1, 4'h3, 8'h00, 8'h00, -1);

        // ORA/DDRA writes leave the timer alone.
        do_cycle("ld6", 1, 0, 4'h6, 8'h10, 0, -1);
        do_cycle("ora_mid", 1, 0, 4'h0, 8'h5A, 0, -1);
        do_cycle("ddra_mid", 1, 0, 4'h1, 8'h0F, 0, -1);
        do_cycle("cnt_kept", 1, 1, 4'h2, 8'h00, 8'h10, -1);

        if (IRQ_EN) begin
            do_cycle("ldC", 1, 0, 4'hC, 8'h02, 0, 1);
            do_cycle("irq_c0", 1, 1, 4'h3, 8'h00, 8'h00, 1);
            do_cycle("irq_c1", 1, 1, 4'h3, 8'h00, 8'h00, 1);
            do_cycle("irq_c2", 1, 1, 4'h3, 8'h00, 8'h00, 1);
            do_cycle("irq_c3", 1, 1, 4'h2, 8'h00, 8'hFF, 0);
            do_cycle("irq_clr", 1, 1, 4'h3, 8'h00, 8'h00, 1);
            do_cycle("ldC1", 1, 0, 4'hC, 8'h01, 0, -1);
            do_cycle("pre_uf", 1, 1, 4'h2, 8'h00, 8'h01, 1);
            do_cycle("uf_rewr", 1, 0, 4'hC, 8'h05, 0, 1);
            do_cycle("rewr_stat", 1, 1, 4'h3, 8'h00, 8'h00, 1);
            do_cycle("rewr_cnt", 1, 1, 4'h2, 8'h00, 8'h04, 1);
        end else begin
            do_cycle("ldC_noirq", 1, 0, 4'hC, 8'h02, 0, 1);
            for (int c = 0; c < 4; c++)
                do_cycle("noirq", 1, 1, 4'h3, 8'h00, (c == 3) ? 8'h80 : 8'h00, 1);
        end

        // Random traffic against the model.
        for (int n = 0; n < 600; n++) begin
            logic       cs, rw;
            logic [3:0] a;
            logic [7:0] d;
            cs = ($urandom_range(0, 9) != 0);
            rw = $urandom_range(0, 1);
            a  = 4'($urandom_range(0, 15));
            d  = 8'($urandom_range(0, 255));
            if (!rw && a[2] && $urandom_range(0, 19) != 0) a[2] = 1'b0;
            if (!rw && a[2]) begin
                a[1] = 1'b0;
                d = 8'($urandom_range(0, 12));
            end
            PA_IN = 8'($urandom_range(0, 255));
            do_cycle("rand", cs, rw, a, d, -1, -1);
        end

        // Reset mid-countdown.
        do_cycle("ld6_rst", 1, 0, 4'hE, 8'h40, 0, -1);
        for (int c = 0; c < 100; c++)
            do_cycle("pre64", 1, 1, 4'h2, 8'h00, (c < 64) ? 8'h40 : 8'h3F, -1);
        CS = 1'b1; RW = 1'b1; ADDR = 4'h2; PA_IN = 8'h00;
        RES = 1'b1;
        model_reset();
        #1;
        check8("rst_mid_cnt", DB_OUT, 8'h00);
        check8("rst_mid_irq", {7'b0, IRQ_N}, 8'h01);
        check8("rst_mid_ora", PA_OUT, 8'h00);
        ADDR = 4'h3;
        #1;
        check8("rst_mid_flag", DB_OUT, 8'h00);
        @(posedge CLK); @(negedge CLK);
        RES = 1'b0;
        for (int j = 0; j < 1024; j++)
            do_cycle("pre1024", 1, 1, 4'h2, 8'h00, 8'h00, 1);
        do_cycle("pre1024_stat", 1, 1, 4'h3, 8'h00, 8'h80, -1);
        do_cycle("pre1024_fe", 1, 1, 4'h2, 8'h00, 8'hFE, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
